// File: rtl/goldschmidt_ctrl_if.sv
// goldschmidt_ctrl_if: request/strobe bundle between a requester and the
// Goldschmidt divider sequencer.
interface goldschmidt_ctrl_if;
  logic       start;
  logic       div0;
  logic       busy;
  logic       done;
  logic       err;
  logic       ld_init;
  logic       sel_init;
  logic       mul_en;
  logic       ld_nd;
  logic       ld_f;
  logic       ld_q;
  logic [2:0] iter;

  // Requester side: raises start, reports the zero-divisor flag.
  modport master (
    output start, div0,
    input  busy, done, err, ld_init, sel_init, mul_en, ld_nd, ld_f, ld_q, iter
  );

  // Sequencer side.
  modport slave (
    input  start, div0,
    output busy, done, err, ld_init, sel_init, mul_en, ld_nd, ld_f, ld_q, iter
  );
endinterface

// File: rtl/goldschmidt_ctrl.sv
// goldschmidt_ctrl: sequencer for an iterative Goldschmidt divider.
// LOAD -> (MUL -> UPD) x ITER -> FIN, with all strobes decoded from state.
// Optional macro GS_DIV0_DETECT_EN adds an ERR state that short-circuits a
// division whose divisor is zero.
module goldschmidt_ctrl #(
  parameter int unsigned ITER = 4
) (
  input  logic               clk,
  input  logic               reset,
  goldschmidt_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MUL  = 3'd2,
    S_UPD  = 3'd3,
    S_FIN  = 3'd4
`ifdef GS_DIV0_DETECT_EN
    ,
    S_ERR  = 3'd5
`endif
  } state_t;

  localparam logic [2:0] ITER_L = 3'(ITER);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_iter;
  logic [2:0] w_iter_inc;

  assign w_iter_inc = r_iter + 3'd1;

  // State register; reset aborts any division in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
`ifdef GS_DIV0_DETECT_EN
          if (bus.div0) w_state_nxt = S_ERR;
          else          w_state_nxt = S_LOAD;
`else
          w_state_nxt = S_LOAD;
`endif
        end
      end
      S_LOAD:  w_state_nxt = S_MUL;
      S_MUL:   w_state_nxt = S_UPD;
      // >= rather than == so a corrupted count can never run past ITER.
      S_UPD:   w_state_nxt = (w_iter_inc >= ITER_L) ? S_FIN : S_MUL;
      S_FIN:   w_state_nxt = S_IDLE;
`ifdef GS_DIV0_DETECT_EN
      S_ERR:   w_state_nxt = S_IDLE;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Iteration counter: zeroed on entry to LOAD so it already reads 0 during
  // LOAD, bumped by each UPD, otherwise held (including FIN and IDLE).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   r_iter <= '0;
    else if (w_state_nxt == S_LOAD)              r_iter <= '0;
    else if (r_state == S_UPD && r_iter < ITER_L) r_iter <= w_iter_inc;
  end

  // Moore output decode from the registered state.
  always_comb begin
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.err      = 1'b0;
    bus.ld_init  = 1'b0;
    bus.sel_init = 1'b0;
    bus.mul_en   = 1'b0;
    bus.ld_nd    = 1'b0;
    bus.ld_f     = 1'b0;
    bus.ld_q     = 1'b0;
    case (r_state)
      S_IDLE: ;
      S_LOAD: begin
        bus.busy     = 1'b1;
        bus.ld_init  = 1'b1;
        bus.sel_init = 1'b1;
      end
      S_MUL: begin
        bus.busy   = 1'b1;
        bus.mul_en = 1'b1;
      end
      S_UPD: begin
        bus.busy  = 1'b1;
        bus.ld_nd = 1'b1;
        bus.ld_f  = 1'b1;
      end
      S_FIN: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        bus.ld_q = 1'b1;
      end
`ifdef GS_DIV0_DETECT_EN
      S_ERR: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        bus.err  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.iter = r_iter;

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// tb_goldschmidt_ctrl: timeline model of the sequencer plus directed and
// randomized stimulus for goldschmidt_ctrl.
module tb_goldschmidt_ctrl;
  localparam int unsigned ITER  = 4;
  localparam int          FIN_T = 2 * ITER + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  goldschmidt_ctrl_if bus();

  goldschmidt_ctrl #(.ITER(ITER)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: an operation is a timeline t = 0 (load) .. FIN_T (finish) after
  // acceptance; an error operation is a single cycle.
  bit m_busy = 1'b0;
  bit m_err  = 1'b0;
  int m_t    = 0;
  int m_iter = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_err = 1'b0; m_t = 0; m_iter = 0;
    end else if (m_busy) begin
      if (m_err) begin
        m_busy = 1'b0; m_err = 1'b0;
      end else if (m_t == FIN_T) begin
        m_busy = 1'b0; m_iter = ITER;
      end else begin
        m_t++;
      end
    end else if (bus.start) begin
      m_busy = 1'b1;
      m_t    = 0;
`ifdef GS_DIV0_DETECT_EN
      if (bus.div0) m_err = 1'b1;
      else          m_iter = 0;
`else
      m_iter = 0;
`endif
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  bit e_run, e_ldinit, e_mul, e_ldnd, e_fin, e_errp;
  int e_iter;

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    e_run    = m_busy && !m_err;
    e_errp   = m_busy && m_err;
    e_ldinit = e_run && (m_t == 0);
    e_mul    = e_run && (m_t >= 1) && (m_t <= 2 * ITER) && (m_t % 2 == 1);
    e_ldnd   = e_run && (m_t >= 2) && (m_t <= 2 * ITER) && (m_t % 2 == 0);
    e_fin    = e_run && (m_t == FIN_T);
    if (!e_run)            e_iter = m_iter;
    else if (m_t == 0)     e_iter = 0;
    else if (m_t <= 2 * ITER) e_iter = (m_t - 1) / 2;
    else                   e_iter = ITER;
    check("busy",     int'(bus.busy),     int'(m_busy));
    check("done",     int'(bus.done),     int'(e_fin || e_errp));
    check("err",      int'(bus.err),      int'(e_errp));
    check("ld_init",  int'(bus.ld_init),  int'(e_ldinit));
    check("sel_init", int'(bus.sel_init), int'(e_ldinit));
    check("mul_en",   int'(bus.mul_en),   int'(e_mul));
    check("ld_nd",    int'(bus.ld_nd),    int'(e_ldnd));
    check("ld_f",     int'(bus.ld_f),     int'(e_ldnd));
    check("ld_q",     int'(bus.ld_q),     int'(e_fin));
    check("iter",     int'(bus.iter),     e_iter);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(bus.busy), 0);
    #1;
  endtask

  int n, n_mul, n_nd, n_ld, d1, d2;
  bit got;

  initial begin
    bus.start = 1'b0;
    bus.div0  = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_iter", int'(bus.iter), 0);
    #1 reset = 1'b0;

    // Single division: LOAD next cycle, ITER mul/upd pairs, done FIN_T later.
    bus.start = 1'b1;
    @(negedge clk);
    check("first_ld_init", int'(bus.ld_init), 1);
    #1 bus.start = 1'b0;
    n = 0; n_mul = 0; n_nd = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      n_mul += int'(bus.mul_en);
      n_nd  += int'(bus.ld_nd);
      got = bus.done;
    end
    check("done_latency", n, 9);
    check("mul_count",    n_mul, 4);
    check("upd_count",    n_nd, 4);
    check("iter_at_done", int'(bus.iter), 4);
    check("ld_q_at_done", int'(bus.ld_q), 1);
    #1;
    tick();
    check("iter_held_idle", int'(bus.iter), 4);

    // start held high: back-to-back operations, done spacing of FIN_T + 2.
    bus.start = 1'b1;
    d1 = -1; d2 = -1; n_ld = 0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      n_ld += int'(bus.ld_init);
      if (bus.done) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
    end
    check("held_first_done", d1, 10);
    check("held_done_gap",   d2 - d1, 11);
    check("held_ld_init",    n_ld, 3);
    #1 bus.start = 1'b0;
    wait_idle("held_drain");

    // Zero divisor.
    bus.start = 1'b1;
    bus.div0  = 1'b1;
    @(negedge clk);
`ifdef GS_DIV0_DETECT_EN
    check("div0_done",    int'(bus.done), 1);
    check("div0_err",     int'(bus.err), 1);
    check("div0_ld_init", int'(bus.ld_init), 0);
    #1 bus.start = 1'b0;
    bus.div0 = 1'b0;
    @(negedge clk);
    check("div0_busy_after", int'(bus.busy), 0);
    #1;
`else
    check("div0_ld_init", int'(bus.ld_init), 1);
    check("div0_err",     int'(bus.err), 0);
    #1 bus.start = 1'b0;
    bus.div0 = 1'b0;
    wait_idle("div0_drain");
`endif

    // Asynchronous reset in the middle of the second UPD.
    bus.start = 1'b1;
    @(negedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("upd2_ld_nd", int'(bus.ld_nd), 1);
    check("upd2_iter",  int'(bus.iter), 1);
    #2 reset = 1'b1;
    #1;
    check("async_busy",  int'(bus.busy), 0);
    check("async_ld_nd", int'(bus.ld_nd), 0);
    check("async_iter",  int'(bus.iter), 0);
    @(negedge clk);
    #1 reset = 1'b0;
    n = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      n += int'(bus.done) + int'(bus.ld_q);
    end
    check("no_done_after_abort", n, 0);
    // First start after reset is accepted on the very next edge.
    #1 bus.start = 1'b1;
    @(negedge clk);
    check("post_reset_accept", int'(bus.ld_init), 1);
    #1 bus.start = 1'b0;
    wait_idle("post_reset_drain");

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 800; c++) begin
      bus.start = ($urandom_range(0, 2) == 0);
      bus.div0  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #($urandom_range(1, 7)) reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
      end else begin
        tick();
      end
    end
    bus.start = 1'b0;
    bus.div0  = 1'b0;
    wait_idle("final_drain");

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always reaches the summary.
  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: got running expected finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
